// File: rtl/bcd_cascade_counter_pkg.sv
// Shared definitions for the cascaded modulo-N counter: radix constants,
// the per-digit operation encoding and the digit-width helper.
package bcd_cascade_counter_pkg;

  localparam int BCD_RADIX = 10;
  localparam int HEX_RADIX = 16;

  typedef enum logic [1:0] {
    OP_HOLD,
    OP_STEP,
    OP_LOAD,
    OP_CLEAR
  } digit_op_e;

  // Bits needed for one digit; never less than 1 so RADIX = 2 still has a bit.
  function automatic int clog2_min1(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/bcd_cascade_counter_modn_digit.sv
// One modulo-RADIX digit with clear > load > step priority and
// at_max/at_min flags feeding the carry chain of the enclosing counter.
module modn_digit
  import bcd_cascade_counter_pkg::*;
#(
  parameter  int RADIX = BCD_RADIX,
  localparam int W     = clog2_min1(RADIX)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         step,
  input  logic         up_dn,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] din,
  output logic [W-1:0] q,
  output logic         at_max,
  output logic         at_min
);

  localparam logic [W-1:0] MAXV = W'(RADIX - 1);

  logic [W-1:0] q_q, q_d;
  digit_op_e    op;

  always_comb begin
    op = OP_HOLD;
    if (clear)     op = OP_CLEAR;
    else if (load) op = OP_LOAD;
    else if (step) op = OP_STEP;
  end

  assign at_max = (q_q == MAXV);
  assign at_min = (q_q == '0);

  always_comb begin
    q_d = q_q;
    case (op)
      OP_CLEAR: q_d = '0;
      // Out-of-range load digits are forced to zero so the digit stays legal.
      OP_LOAD:  q_d = ({1'b0, din} < (W + 1)'(RADIX)) ? din : '0;
      OP_STEP: begin
        if (up_dn) q_d = at_max ? '0   : q_q + 1'b1;
        else       q_d = at_min ? MAXV : q_q - 1'b1;
      end
      default:  q_d = q_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/bcd_cascade_counter.sv
// N_DIGITS-digit modulo-RADIX up/down counter with synchronous carry/borrow,
// clear, parallel load with illegal-digit flag, and a cascadable terminal count.
module bcd_cascade_counter
  import bcd_cascade_counter_pkg::*;
#(
  parameter  int RADIX    = BCD_RADIX,
  parameter  int N_DIGITS = 2,
  localparam int DIGIT_W  = clog2_min1(RADIX)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        cin,
  input  logic                        up_dn,
  input  logic                        clear,
  input  logic                        load,
  input  logic [N_DIGITS*DIGIT_W-1:0] load_val,
  output logic [N_DIGITS*DIGIT_W-1:0] out,
  output logic                        tc,
  output logic                        load_err
);

  logic                step_en;
  logic [N_DIGITS:0]   carry;
  logic [N_DIGITS-1:0] at_max, at_min, illegal;
  logic                load_err_q, load_err_d;

  assign step_en  = en & cin;
  assign carry[0] = 1'b1;

  // carry[k] is high when every digit below k sits at its wrap value for the
  // current direction, so all digits step on the same edge without rippling.
  for (genvar k = 0; k < N_DIGITS; k++) begin : g_digit
    logic [DIGIT_W-1:0] din_k;

    assign din_k        = load_val[k*DIGIT_W +: DIGIT_W];
    assign illegal[k]   = ({1'b0, din_k} >= (DIGIT_W + 1)'(RADIX));
    assign carry[k + 1] = carry[k] & (up_dn ? at_max[k] : at_min[k]);

    modn_digit #(
      .RADIX (RADIX)
    ) u_digit (
      .clk    (clk),
      .rst    (rst),
      .step   (step_en & carry[k]),
      .up_dn  (up_dn),
      .clear  (clear),
      .load   (load),
      .din    (din_k),
      .q      (out[k*DIGIT_W +: DIGIT_W]),
      .at_max (at_max[k]),
      .at_min (at_min[k])
    );
  end

  assign tc = step_en & carry[N_DIGITS];

  always_comb begin
    load_err_d = 1'b0;
    if (!clear && load) load_err_d = |illegal;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) load_err_q <= 1'b0;
    else     load_err_q <= load_err_d;
  end

  assign load_err = load_err_q;

endmodule
